// File: rtl/eth_desc_pkg.sv
// eth_desc_pkg: shared types and defaults for the descriptor memory port arbiter
package eth_desc_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} arb_state_t;
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;
endpackage

// File: rtl/desc_rr_lock_arb.sv
// desc_rr_lock_arb: two-way round-robin grant with a bounded per-requester lock
module desc_rr_lock_arb
    import eth_desc_pkg::*;
#(
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] grant,
    output logic       lock_timeout
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK_CYCLES);
    arb_state_t state;
    logic       last_grant;
    logic [7:0] lock_cnt;
    logic       locked, own, timeout, hold;
    logic [1:0] rr_grant;
    always_comb begin
        locked   = state != UNLOCKED;
        own      = state == LOCKED1;
        timeout  = locked & lock[own] & (lock_cnt == MAX_CNT);
        hold     = locked & lock[own] & ~timeout;
        rr_grant = (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
        grant    = reset   ? 2'b00 :
                   hold    ? req & (own ? 2'b10 : 2'b01) :
                   timeout ? req & (own ? 2'b01 : 2'b10) : rr_grant;
        lock_timeout = timeout & ~reset;
    end
    // A broken lock charges the turn to its owner so the other side wins next contention
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= UNLOCKED;
            last_grant <= 1'b1;
            lock_cnt   <= 8'd0;
        end else begin
            last_grant <= timeout ? own : (|grant) ? grant[1] : last_grant;
            if (hold) begin
                lock_cnt <= lock_cnt + 8'd1;
            end else begin
                state    <= (grant[0] & lock[0]) ? LOCKED0 : (grant[1] & lock[1]) ? LOCKED1 : UNLOCKED;
                lock_cnt <= (|(grant & lock)) ? 8'd1 : 8'd0;
            end
        end
    end
endmodule

// File: rtl/descriptor_port_arbiter.sv
// descriptor_port_arbiter: shares one descriptor memory port between the TX and RX descriptor walkers
module descriptor_port_arbiter
    import eth_desc_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  lock_timeout
);
    logic [1:0]          req, grant;
    logic                sel, acc, wr, rd;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   wd_q;
    rd_tag_t             tag;
    assign req = {m1_read | m1_write, m0_read | m0_write};
    desc_rr_lock_arb #(.MAX_LOCK_CYCLES(MAX_LOCK_CYCLES)) u_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .lock         ({m1_lock, m0_lock}),
        .grant        (grant),
        .lock_timeout (lock_timeout)
    );
    always_comb begin
        sel            = grant[1];
        acc            = |(req & grant);
        wr             = sel ? m1_write : m0_write;
        rd             = acc & ~wr & (sel ? m1_read : m0_read);
        m0_waitrequest = ~grant[0] & (req[0] | ~|grant);
        m1_waitrequest = ~grant[1] & (req[1] | ~|grant);
        mem_chipselect = acc;
        mem_write      = acc & wr;
        mem_clken      = 1'b1;
        mem_address    = acc ? (sel ? m1_address : m0_address) : addr_q;
        mem_byteenable = acc ? (sel ? m1_byteenable : m0_byteenable) : be_q;
        mem_writedata  = acc ? (sel ? m1_writedata : m0_writedata) : wd_q;
        m0_readdata    = mem_readdata;
        m1_readdata    = mem_readdata;
        m0_readdatavalid = tag.valid & ~tag.owner & ~reset;
        m1_readdatavalid = tag.valid & tag.owner & ~reset;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            be_q   <= '0;
            wd_q   <= '0;
            tag    <= '0;
        end else begin
            addr_q <= mem_address;
            be_q   <= mem_byteenable;
            wd_q   <= mem_writedata;
            tag    <= '{valid: rd, owner: sel};
        end
    end
endmodule

// File: tb/tb_descriptor_port_arbiter.sv
// tb_descriptor_port_arbiter: directed stimulus with a read-data scoreboard for descriptor_port_arbiter
module tb_descriptor_port_arbiter;
    logic        clk = 0, reset = 1;
    logic [9:0]  a0 = 0, a1 = 0;
    logic [3:0]  be0 = 0, be1 = 0;
    logic        r0 = 0, w0 = 0, l0 = 0, r1 = 0, w1 = 0, l1 = 0;
    logic [31:0] wd0 = 0, wd1 = 0;
    logic        wait0, wait1, rdv0, rdv1, cs, mwr, clken, tmo;
    logic [31:0] rdata0, rdata1, mwd, mrd;
    logic [9:0]  maddr;
    logic [3:0]  mbe;
    logic [31:0] mem [1024];
    logic [31:0] wtmp;
    logic [32:0] sb_q[$];
    logic [32:0] e;
    logic        skip = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    descriptor_port_arbiter #(.MAX_LOCK_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .m0_address(a0), .m0_byteenable(be0), .m0_read(r0), .m0_write(w0), .m0_writedata(wd0),
        .m0_lock(l0), .m0_waitrequest(wait0), .m0_readdata(rdata0), .m0_readdatavalid(rdv0),
        .m1_address(a1), .m1_byteenable(be1), .m1_read(r1), .m1_write(w1), .m1_writedata(wd1),
        .m1_lock(l1), .m1_waitrequest(wait1), .m1_readdata(rdata1), .m1_readdatavalid(rdv1),
        .mem_address(maddr), .mem_byteenable(mbe), .mem_chipselect(cs), .mem_write(mwr),
        .mem_writedata(mwd), .mem_clken(clken), .mem_readdata(mrd), .lock_timeout(tmo)
    );

    // Synchronous single-port RAM behind the arbiter, one-cycle read latency
    always @(posedge clk) begin
        if (clken & cs) begin
            if (mwr) begin
                wtmp = mem[maddr];
                for (int b = 0; b < 4; b++) if (mbe[b]) wtmp[8*b +: 8] = mwd[8*b +: 8];
                mem[maddr] <= wtmp;
            end
            mrd <= mem[maddr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rdv0 | rdv1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdv: got rdv0=%b rdv1=%b expected none at %0t", rdv0, rdv1, $time);
            end else begin
                e = sb_q.pop_front();
                chk("rdv_owner", {31'd0, rdv1}, {31'd0, e[32]});
                chk("rdv_single", {31'd0, rdv0 & rdv1}, 32'd0);
                chk("rdv_data", e[32] ? rdata1 : rdata0, e[31:0]);
            end
        end
    end

    task automatic tick(input logic ew0, input logic ew1, input logic eto, input logic [31:0] ed);
        #3;
        chk("wait0", {31'd0, wait0}, {31'd0, ew0});
        chk("wait1", {31'd0, wait1}, {31'd0, ew1});
        chk("lock_timeout", {31'd0, tmo}, {31'd0, eto});
        chk("chipselect", {31'd0, cs}, {31'd0, ((r0 | w0) & ~ew0) | ((r1 | w1) & ~ew1)});
        if (!skip && r0 && !w0 && !ew0) sb_q.push_back({1'b0, ed});
        if (!skip && r1 && !w1 && !ew1) sb_q.push_back({1'b1, ed});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {r0, w0, l0, r1, w1, l1} = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        r0 = 1; r1 = 1; w0 = 0; w1 = 0; l0 = 0; l1 = 0;
        tick(1, 1, 0, 0);
        chk("reset_maddr", {22'd0, maddr}, 32'd0);
        reset = 0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | i;
        @(posedge clk);
        #1;
        do_reset();
        // single read by m0
        r0 = 1; a0 = 10'd5;
        tick(0, 0, 0, 32'hA5A5_0005);
        idle();
        tick(1, 1, 0, 0);
        // contention from reset alternates starting with m0
        do_reset();
        r0 = 1; a0 = 10'd20; r1 = 1; a1 = 10'd40;
        for (int c = 0; c < 6; c++) tick(c % 2 == 1, c % 2 == 0, 0, (c % 2 == 0) ? 32'hA5A5_0014 : 32'hA5A5_0028);
        idle();
        tick(1, 1, 0, 0);
        // partial write at the top address, then read it back
        w1 = 1; a1 = 10'h3FF; wd1 = 32'h1234_5678; be1 = 4'h3;
        tick(0, 0, 0, 0);
        idle();
        r0 = 1; a0 = 10'h3FF;
        tick(0, 0, 0, 32'hA5A5_5678);
        idle();
        tick(1, 1, 0, 0);
        // lock held across read/write, released with m1 granted the same cycle
        do_reset();
        r0 = 1; a0 = 10'd10; l0 = 1; r1 = 1; a1 = 10'd40;
        tick(0, 1, 0, 32'hA5A5_000A);
        r0 = 0; w0 = 1; wd0 = 32'hCAFE_0000; be0 = 4'hF;
        tick(0, 1, 0, 0);
        w0 = 0;
        tick(1, 1, 0, 0);
        l0 = 0;
        tick(0, 0, 0, 32'hA5A5_0028);
        r1 = 0; r0 = 1; a0 = 10'd10;
        tick(0, 0, 0, 32'hCAFE_0000);
        idle();
        tick(1, 1, 0, 0);
        // lock held past the limit is broken in the 16th locked cycle
        do_reset();
        r0 = 1; a0 = 10'd5; l0 = 1; r1 = 1; a1 = 10'd40;
        for (int c = 0; c < 20; c++)
            tick(c == 16 || c == 17, !(c == 16 || c == 17), c == 16, (c == 16 || c == 17) ? 32'hA5A5_0028 : 32'hA5A5_0005);
        idle();
        tick(1, 1, 0, 0);
        // reset right after an accepted read drops its response
        do_reset();
        r0 = 1; a0 = 10'd5; skip = 1;
        tick(0, 0, 0, 0);
        reset = 1; r1 = 1;
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        reset = 0; skip = 0; a1 = 10'd40;
        tick(0, 1, 0, 32'hA5A5_0005);
        tick(1, 0, 0, 32'hA5A5_0028);
        idle();
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/descriptor_port_arbiter.md
Name: descriptor_port_arbiter

Overview:
- Shares one port of the 1024x32 dual-port descriptor memory between two Avalon-MM requesters, m0 (TX DMA descriptor walker) and m1 (RX DMA descriptor walker).
- Arbitration is round-robin, with an optional bounded lock so one requester can finish an atomic read-modify-write of a descriptor status word.
- Sits between the two DMA descriptor engines and the memory's second slave port.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_LOCK_CYCLES, 16, maximum consecutive cycles one requester may hold a lock; legal range 2..255.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- mN_address  in  ADDR_W  word address (N = 0, 1; same for every mN_ port below).
- mN_byteenable  in  DATA_W/8  write byte enables.
- mN_read  in  1  read request.
- mN_write  in  1  write request.
- mN_writedata  in  DATA_W  write data.
- mN_lock  in  1  hold the grant across successive transfers.
- mN_waitrequest  out  1  request not accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  readdata valid for one cycle.
- mem_address  out  ADDR_W  to memory port.
- mem_byteenable  out  DATA_W/8  to memory port.
- mem_chipselect  out  1  to memory port.
- mem_write  out  1  to memory port.
- mem_writedata  out  DATA_W  to memory port.
- mem_clken  out  1  tied 1.
- mem_readdata  in  DATA_W  memory q, valid one cycle after the address is presented.
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly broken.

Behaviour:
- Definitions: reqN = mN_read | mN_write. If both read and write are asserted, the write is performed and no readdatavalid is produced.
- Grant is combinational in the cycle. mN_waitrequest = reqN & ~grantN. When no requester is granted, mN_waitrequest = 1. An accepted transfer is reqN & grantN.
- Memory outputs are muxed from the granted requester. mem_chipselect = accepted. mem_write = accepted write. When idle, mem_address, mem_byteenable and mem_writedata hold their last value.
- Read latency is fixed at 1. A registered tag {valid, owner} is captured on every accepted read. Next cycle, mN_readdatavalid = tag.valid & (tag.owner == N). mN_readdata = mem_readdata for both requesters. Back-to-back reads are accepted every cycle, including alternating owners.
- Round-robin uses a last_grant register:
  - Both requesting, unlocked: grant the one that is not last_grant.
  - One requesting: grant it.
  - last_grant updates on every accepted transfer.
- State machine: UNLOCKED, LOCKED0, LOCKED1.
  - UNLOCKED -> LOCKEDN when mN is granted with mN_lock = 1. lock_cnt is loaded with 1.
  - LOCKEDN: only mN may be granted; the other requester sees waitrequest = 1. lock_cnt increments every cycle, whether or not mN requests.
  - LOCKEDN -> UNLOCKED when mN_lock = 0. Arbitration in that same cycle is normal round-robin.
  - LOCKEDN -> UNLOCKED forced when lock_cnt == MAX_LOCK_CYCLES and mN_lock is still 1. In that cycle, pulse lock_timeout and grant the other requester if it is requesting. last_grant is forced to N, so the next contention goes to the other requester. mN cannot re-lock until it is granted again through normal round-robin.
- Reset values:
  - state = UNLOCKED, last_grant = 1 (m0 wins the first contention), lock_cnt = 0, tag.valid = 0.
  - All readdatavalid outputs = 0, lock_timeout = 0.
  - mem_chipselect and mem_write = 0; mem_address, mem_byteenable and mem_writedata = 0.
  - All waitrequest = 1 while reset is high.
- Reset mid-operation: an in-flight read tag is dropped, so no readdatavalid is issued after reset. Any lock is released.

Decomposition:
- Shared package (eth_desc_pkg): ADDR_W/DATA_W defaults, the arbiter state enum, and the read-tag struct {valid, owner}.
- One natural sub-module: desc_rr_lock_arb. It holds state, last_grant, lock_cnt and the grant logic, taking req[1:0] and lock[1:0] and producing grant[1:0] and lock_timeout.
- The top level holds the memory muxing and the read tag.

Test Plan:
- Memory pre-filled with word 5 = 0xA5A5_0005, address 5 read by m0 alone -> waitrequest 0 same cycle; next cycle m0_readdatavalid = 1 with 0xA5A5_0005; m1_readdatavalid stays 0.
- m0 and m1 both read continuously for 6 cycles from reset -> grants m0,m1,m0,m1,m0,m1; each readdatavalid pulses the cycle after its grant with correct data.
- m1 writes 0x1234_5678 to address 0x3FF with byteenable 0x3, then m0 reads 0x3FF -> low half 0x5678, upper half unchanged; wrap address 0x3FF is handled.
- m0 asserts lock and does read@10, write@10 while m1 requests continuously -> m1 waits until m0_lock drops, then m1 is granted the same cycle.
- m0 holds lock for 20 cycles with MAX_LOCK_CYCLES = 16 -> lock_timeout pulses in the 16th locked cycle; m1 is granted in that cycle; m0 is regranted only via round-robin.
- Reset asserted the cycle after an accepted read -> no readdatavalid follows; all waitrequest = 1 during reset; first contention after reset goes to m0.
